// File: rtl/gcm_pkg.sv
// Shared constants and types for the GCM counter-pair generator.
// Word-phase codes, FSM encoding and the registered output word layout.
package gcm_pkg;

    localparam int unsigned GCM_IV_W   = 96;
    localparam int unsigned GCM_CTR_W  = 32;
    localparam int unsigned GCM_BLK_W  = GCM_IV_W + GCM_CTR_W;
    localparam int unsigned GCM_TEXT_W = 289;
    localparam int unsigned GCM_PHS_W  = 4;

    localparam logic [GCM_PHS_W-1:0] PKT_FIRST_WORD  = 4'd1;
    localparam logic [GCM_PHS_W-1:0] PKT_SECOND_WORD = 4'd2;
    localparam logic [GCM_PHS_W-1:0] PKT_INNER_WORD  = 4'd4;

    typedef enum logic {
        IDLE,
        IN_PKT
    } ctr_fsm_e;

    typedef struct packed {
        logic [GCM_TEXT_W-1:0]  text;
        logic [GCM_PHS_W-1:0]   state;
        logic                   last;
        logic [2*GCM_BLK_W-1:0] ctr;
        logic [GCM_BLK_W-1:0]   j0;
    } gcm_out_word_t;

    function automatic logic [GCM_BLK_W-1:0] gcm_ctr_block(
        input logic [GCM_IV_W-1:0]  iv,
        input logic [GCM_CTR_W-1:0] ctr
    );
        return {iv, ctr};
    endfunction

endpackage

// File: rtl/gcm_pipe_reg.sv
// Single-stage valid/ready register; upstream ready is combinational from the
// held valid and downstream ready, so a full stage can still pass one word per cycle.
module gcm_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [Width-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [Width-1:0] dn_data,
    input  logic             dn_ready
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // An accepted word that produces no output still advances the stage,
    // clearing valid when the held word leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/gcm_ctr_pair_gen.sv
// Tags each packet word with two GCM counter blocks {IV, ctr} and {IV, ctr+1}
// plus J0, tracking packet framing and flagging protocol errors.
module gcm_ctr_pair_gen
    import gcm_pkg::*;
#(
    parameter int unsigned          IV_LSB   = 160,
    parameter logic [GCM_CTR_W-1:0] CTR_INIT = 32'd2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GCM_TEXT_W-1:0]  i_text,
    input  logic [GCM_PHS_W-1:0]   i_state,
    input  logic                   i_last,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [GCM_TEXT_W-1:0]  o_text,
    output logic [GCM_PHS_W-1:0]   o_state,
    output logic                   o_last,
    output logic [2*GCM_BLK_W-1:0] o_ctr,
    output logic [GCM_BLK_W-1:0]   o_j0,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_err
);

    ctr_fsm_e               state_q, state_d;
    logic [GCM_IV_W-1:0]    iv_q, iv_d;
    logic [GCM_CTR_W-1:0]   ctr_q, ctr_d;
    logic                   err_q;

    logic                   accept;
    logic                   is_first;
    logic                   is_cont;
    logic                   emit;
    logic                   bad_word;
    logic [GCM_IV_W-1:0]    blk_iv;
    logic [GCM_CTR_W-1:0]   blk_ctr;
    logic [GCM_CTR_W-1:0]   blk_ctr_nxt;
    gcm_out_word_t          up_word;
    gcm_out_word_t          dn_word;

    assign accept   = i_valid && o_ready;
    assign is_first = (i_state == PKT_FIRST_WORD);
    assign is_cont  = (i_state == PKT_SECOND_WORD) || (i_state == PKT_INNER_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iv_q    <= '0;
            ctr_q   <= CTR_INIT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iv_q    <= iv_d;
            ctr_q   <= ctr_d;
            err_q   <= err_q | bad_word;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (is_first && !i_last) begin
                        state_d = IN_PKT;
                    end
                end
                IN_PKT: begin
                    // A FIRST word mid-packet restarts framing exactly as from IDLE.
                    if (is_first) begin
                        state_d = i_last ? IDLE : IN_PKT;
                    end else if (is_cont && i_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        emit     = 1'b0;
        bad_word = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    emit     = is_first;
                    bad_word = !is_first;
                end
                IN_PKT: begin
                    emit     = is_first || is_cont;
                    bad_word = !is_cont;
                end
                default: begin
                    emit     = 1'b0;
                    bad_word = 1'b1;
                end
            endcase
        end
    end

    // A FIRST word forms its blocks from its own IV and CTR_INIT directly, so
    // nothing waits on the latched values during a restart.
    always_comb begin
        blk_iv      = is_first ? i_text[IV_LSB +: GCM_IV_W] : iv_q;
        blk_ctr     = is_first ? CTR_INIT : ctr_q;
        blk_ctr_nxt = blk_ctr + 32'd1;
        iv_d        = (accept && is_first) ? blk_iv : iv_q;
        ctr_d       = emit ? (blk_ctr + 32'd2) : ctr_q;

        up_word.text  = i_text;
        up_word.state = i_state;
        up_word.last  = i_last;
        up_word.ctr   = {gcm_ctr_block(blk_iv, blk_ctr), gcm_ctr_block(blk_iv, blk_ctr_nxt)};
        up_word.j0    = gcm_ctr_block(blk_iv, 32'd1);
    end

    gcm_pipe_reg #(
        .Width($bits(gcm_out_word_t))
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .up_valid (emit),
        .up_data  (up_word),
        .up_ready (o_ready),
        .dn_valid (o_valid),
        .dn_data  (dn_word),
        .dn_ready (i_ready)
    );

    assign o_text  = dn_word.text;
    assign o_state = dn_word.state;
    assign o_last  = dn_word.last;
    assign o_ctr   = dn_word.ctr;
    assign o_j0    = dn_word.j0;
    assign o_err   = err_q;

endmodule

// File: tb/tb_gcm_ctr_pair_gen.sv
// Bench for gcm_ctr_pair_gen: two instances (CTR_INIT 2 and FFFFFFFE) share stimulus
// and are compared each cycle against a packet-level reference model.
module tb_gcm_ctr_pair_gen;

    localparam logic [31:0] INIT_A = 32'd2;
    localparam logic [31:0] INIT_B = 32'hFFFF_FFFE;
    localparam logic [95:0] IV_CAFE = 96'hCAFE0000_00000000_00000001;
    localparam logic [95:0] IV_BEEF = 96'hBEEF1234_5678ABCD_EF012345;

    logic         clk = 1'b0;
    logic         rst;
    logic [288:0] i_text;
    logic [3:0]   i_state;
    logic         i_last;
    logic         i_valid;
    logic         i_ready;

    logic         a_o_ready, a_o_last, a_o_valid, a_o_err;
    logic [288:0] a_o_text;
    logic [3:0]   a_o_state;
    logic [255:0] a_o_ctr;
    logic [127:0] a_o_j0;
    logic         b_o_ready, b_o_last, b_o_valid, b_o_err;
    logic [288:0] b_o_text;
    logic [3:0]   b_o_state;
    logic [255:0] b_o_ctr;
    logic [127:0] b_o_j0;

    always #5 clk = ~clk;

    gcm_ctr_pair_gen #(.IV_LSB(160), .CTR_INIT(INIT_A)) u_dut_a (
        .clk(clk), .rst(rst), .i_text(i_text), .i_state(i_state), .i_last(i_last),
        .i_valid(i_valid), .o_ready(a_o_ready), .o_text(a_o_text), .o_state(a_o_state),
        .o_last(a_o_last), .o_ctr(a_o_ctr), .o_j0(a_o_j0), .o_valid(a_o_valid),
        .i_ready(i_ready), .o_err(a_o_err)
    );

    gcm_ctr_pair_gen #(.IV_LSB(160), .CTR_INIT(INIT_B)) u_dut_b (
        .clk(clk), .rst(rst), .i_text(i_text), .i_state(i_state), .i_last(i_last),
        .i_valid(i_valid), .o_ready(b_o_ready), .o_text(b_o_text), .o_state(b_o_state),
        .o_last(b_o_last), .o_ctr(b_o_ctr), .o_j0(b_o_j0), .o_valid(b_o_valid),
        .i_ready(i_ready), .o_err(b_o_err)
    );

    typedef struct {
        logic [288:0] text;
        logic [3:0]   state;
        logic         last;
        logic [95:0]  iv;
        logic [31:0]  ca;
        logic [31:0]  cb;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] seen_a[$];
    logic [31:0] seen_b[$];
    logic        seen_last[$];
    bit          m_in_pkt, m_err, m_rdy;
    logic [95:0] m_iv;
    logic [31:0] m_ca, m_cb;
    int          n_checks = 0;
    int          n_bad = 0;
    bit          rand_bp = 1'b0;
    int          stall_left = 0;
    int          last_wait = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [288:0] rnd_text(input logic [95:0] iv);
        logic [288:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        t[288] = 1'($urandom_range(0, 1));
        t[255:160] = iv;
        return t;
    endfunction

    function automatic logic [95:0] rnd_iv();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic model_word(input logic [288:0] t, input logic [3:0] s, input logic l);
        exp_t e;
        e.text = t; e.state = s; e.last = l;
        if (s == 4'd1) begin
            if (m_in_pkt) m_err = 1'b1;
            m_iv = t[255:160];
            e.iv = m_iv; e.ca = INIT_A; e.cb = INIT_B;
            exp_q.push_back(e);
            m_ca = INIT_A + 32'd2;
            m_cb = INIT_B + 32'd2;
            m_in_pkt = !l;
        end else if (s == 4'd2 || s == 4'd4) begin
            if (!m_in_pkt) begin
                m_err = 1'b1;
            end else begin
                e.iv = m_iv; e.ca = m_ca; e.cb = m_cb;
                exp_q.push_back(e);
                m_ca = m_ca + 32'd2;
                m_cb = m_cb + 32'd2;
                if (l) m_in_pkt = 1'b0;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Reference model: advances on each rising edge from the inputs alone.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_in_pkt = 1'b0; m_err = 1'b0; m_iv = '0;
            m_ca = INIT_A; m_cb = INIT_B;
        end else begin
            m_rdy = (exp_q.size() == 0) || i_ready;
            if (exp_q.size() != 0 && i_ready) void'(exp_q.pop_front());
            if (i_valid && m_rdy) model_word(i_text, i_state, i_last);
        end
    end

    // Monitor: compares every output on the falling edge.
    initial forever begin
        bit          ev;
        exp_t        e;
        logic [31:0] a1, b1;
        @(negedge clk);
        ev = (exp_q.size() != 0);
        check("valid_a", 512'(a_o_valid), 512'(ev));
        check("valid_b", 512'(b_o_valid), 512'(ev));
        check("ready_a", 512'(a_o_ready), 512'(!ev || i_ready));
        check("ready_b", 512'(b_o_ready), 512'(!ev || i_ready));
        check("err_a", 512'(a_o_err), 512'(m_err));
        check("err_b", 512'(b_o_err), 512'(m_err));
        if (ev) begin
            e  = exp_q[0];
            a1 = e.ca + 32'd1;
            b1 = e.cb + 32'd1;
            check("text", 512'(a_o_text), 512'(e.text));
            check("state", 512'(a_o_state), 512'(e.state));
            check("last", 512'(a_o_last), 512'(e.last));
            check("ctr_a", 512'(a_o_ctr), 512'({e.iv, e.ca, e.iv, a1}));
            check("ctr_b", 512'(b_o_ctr), 512'({e.iv, e.cb, e.iv, b1}));
            check("j0_a", 512'(a_o_j0), 512'({e.iv, 32'd1}));
            check("j0_b", 512'(b_o_j0), 512'({e.iv, 32'd1}));
            if (i_ready) begin
                seen_a.push_back(a_o_ctr[159:128]);
                seen_b.push_back(b_o_ctr[159:128]);
                seen_last.push_back(a_o_last);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ready();
        if (stall_left > 0) begin
            i_ready = 1'b0;
            stall_left--;
        end else begin
            i_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            set_ready();
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic [288:0] t, input logic [3:0] s, input logic l);
        bit done;
        done = 1'b0;
        last_wait = 0;
        i_text = t; i_state = s; i_last = l; i_valid = 1'b1;
        while (!done) begin
            set_ready();
            @(negedge clk);
            done = a_o_ready;
            @(posedge clk); #1;
            last_wait++;
            if (!done && last_wait > 60) begin
                check("accept_timeout", 512'(0), 512'(1));
                done = 1'b1;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic clear_seen();
        seen_a.delete(); seen_b.delete(); seen_last.delete();
    endtask

    task automatic check_seen(input string tag, input int n, input logic [31:0] base);
        check({tag, "_count"}, 512'(seen_a.size()), 512'(n));
        for (int k = 0; k < n && k < seen_a.size(); k++) begin
            check({tag, "_ctr"}, 512'(seen_a[k]), 512'(base + 32'(2 * k)));
        end
    endtask

    task automatic run_packet(input logic [95:0] iv, input int len);
        for (int k = 0; k < len; k++) begin
            drive(rnd_text(k == 0 ? iv : rnd_iv()), (k == 0) ? 4'd1 : ((k == 1) ? 4'd2 : 4'd4),
                  k == len - 1);
        end
    endtask

    initial begin
        logic [3:0] bad_code;
        int         len;
        int         r;
        rst = 1'b1; i_valid = 1'b0; i_text = '0; i_state = '0; i_last = 1'b0; i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", 512'(a_o_valid), 512'(0));
        check("rst_err", 512'(a_o_err), 512'(0));
        check("rst_text", 512'(a_o_text), 512'(0));
        check("rst_ctr", 512'(a_o_ctr), 512'(0));
        check("rst_j0", 512'(a_o_j0), 512'(0));
        check("rst_state_last", 512'({a_o_state, a_o_last}), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 3-word packet, no stall.
        clear_seen();
        run_packet(IV_CAFE, 3);
        idle(3);
        check_seen("pkt3", 3, 32'd2);
        if (seen_last.size() == 3) begin
            check("pkt3_last", 512'({seen_last[0], seen_last[1], seen_last[2]}), 512'(3'b001));
        end
        // The wrapping instance sees FFFFFFFE, 00000000, 00000002 on the same stream.
        if (seen_b.size() == 3) begin
            check("wrap_b0", 512'(seen_b[0]), 512'(32'hFFFF_FFFE));
            check("wrap_b1", 512'(seen_b[1]), 512'(32'h0000_0000));
            check("wrap_b2", 512'(seen_b[2]), 512'(32'h0000_0002));
        end

        // Same packet with beat 2 held for three cycles.
        clear_seen();
        drive(rnd_text(IV_CAFE), 4'd1, 1'b0);
        drive(rnd_text(rnd_iv()), 4'd2, 1'b0);
        stall_left = 3;
        drive(rnd_text(rnd_iv()), 4'd4, 1'b1);
        check("stall_wait", 512'(last_wait), 512'(4));
        idle(3);
        check_seen("stall", 3, 32'd2);

        // 2-word packet on the wrapping instance.
        clear_seen();
        run_packet(IV_BEEF, 2);
        idle(3);
        check("wrap2_count", 512'(seen_b.size()), 512'(2));
        if (seen_b.size() == 2) begin
            check("wrap2_b0", 512'(seen_b[0]), 512'(32'hFFFF_FFFE));
            check("wrap2_b1", 512'(seen_b[1]), 512'(32'h0000_0000));
        end

        // INNER in IDLE is dropped and flags an error; the next FIRST emits normally.
        clear_seen();
        check("err_before", 512'(a_o_err), 512'(0));
        drive(rnd_text(rnd_iv()), 4'd4, 1'b0);
        idle(2);
        check("err_inner", 512'(a_o_err), 512'(1));
        check("inner_no_out", 512'(seen_a.size()), 512'(0));
        drive(rnd_text(IV_CAFE), 4'd1, 1'b1);
        idle(3);
        check_seen("after_err", 1, 32'd2);
        check("err_sticky", 512'(a_o_err), 512'(1));

        // FIRST mid-packet restarts with the new IV.
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        clear_seen();
        drive(rnd_text(IV_CAFE), 4'd1, 1'b0);
        drive(rnd_text(rnd_iv()), 4'd2, 1'b0);
        drive(rnd_text(IV_BEEF), 4'd1, 1'b0);
        drive(rnd_text(rnd_iv()), 4'd2, 1'b1);
        idle(3);
        check("restart_err", 512'(a_o_err), 512'(1));
        check("restart_count", 512'(seen_a.size()), 512'(4));
        if (seen_a.size() == 4) begin
            check("restart_ctr", 512'({seen_a[2], seen_a[3]}), 512'({32'd2, 32'd4}));
        end

        // Reset while a word is held mid-packet.
        clear_seen();
        drive(rnd_text(IV_CAFE), 4'd1, 1'b0);
        i_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_drop", 512'(a_o_valid), 512'(0));
        check("rst_err_clr", 512'(a_o_err), 512'(0));
        @(posedge clk); #1;
        drive(rnd_text(IV_BEEF), 4'd1, 1'b1);
        idle(3);
        check_seen("post_rst", 1, 32'd2);

        // Randomised packets with backpressure and injected protocol errors.
        rand_bp = 1'b1;
        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drive(rnd_text(rnd_iv()), ($urandom_range(0, 1) != 0) ? 4'd2 : 4'd4, 1'($urandom_range(0, 1)));
            end else if (r == 1) begin
                do bad_code = 4'($urandom_range(0, 15));
                while (bad_code == 4'd1 || bad_code == 4'd2 || bad_code == 4'd4);
                drive(rnd_text(rnd_iv()), bad_code, 1'($urandom_range(0, 1)));
            end
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                drive(rnd_text(rnd_iv()), (k == 0) ? 4'd1 : ((k == 1) ? 4'd2 : 4'd4),
                      (k == len - 1) && (r != 2));
            end
            idle($urandom_range(0, 2));
        end
        rand_bp = 1'b0;
        idle(5);
        check("drained", 512'(a_o_valid), 512'(0));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
